ntt_sched: RTL and testbench

Issue scheduler for a fixed-latency pipelined butterfly unit in the NTT/INTT datapath. On a start pulse it sequences all LOG_N stages of an in-place radix-2 transform. Each cycle it issues one butterfly: coefficient-pair read addresses, twiddle index and mode. Write-back enable and addresses are re-timed through an internal PIPE_LAT-deep delay line, and the block inserts a drain gap between stages to remove read-after-write hazards.

---
 rtl/ntt_sched.sv | 171 +++++++++++++++++
 tb/tb_ntt_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_sched.sv
// ============================================================================
// Module  : ntt_sched
// Purpose : Issue scheduler for a pipelined radix-2 NTT/INTT butterfly unit.
//           Optional macro NTT_SCHED_PERF_EN adds the cyc_cnt output.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ntt_sched #(
    parameter int LOG_N    = 8,
    parameter int PIPE_LAT = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG_N-1:0] rd_addr_a,
    output logic [LOG_N-1:0] rd_addr_b,
    output logic [LOG_N-1:0] tw_idx,
    output logic             bfu_mode,
    output logic             wr_en,
    output logic [LOG_N-1:0] wr_addr_a,
    output logic [LOG_N-1:0] wr_addr_b
`ifdef NTT_SCHED_PERF_EN
    ,
    output logic [31:0]      cyc_cnt
`endif
);

    localparam int c_SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;
    localparam int c_DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int c_LW = 2 * LOG_N + 1;

    localparam logic [LOG_N-1:0] c_HALF_LAST  = LOG_N'((1 << (LOG_N - 1)) - 1);
    localparam logic [c_SW-1:0]  c_LAST_S     = c_SW'(LOG_N - 1);
    localparam logic [c_DW-1:0]  c_DRAIN_LOAD = c_DW'(PIPE_LAT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [c_SW-1:0]  r_s;
    logic [LOG_N-1:0] r_i;
    logic [c_DW-1:0]  r_drain;
    logic             r_mode;
    logic [c_LW-1:0]  r_dly [PIPE_LAT];

    logic [c_SW-1:0]  w_m;
    logic [LOG_N-1:0] w_g;
    logic [LOG_N-1:0] w_p;
    logic [LOG_N-1:0] w_a;
    logic [LOG_N-1:0] w_b;
    logic [LOG_N-1:0] w_tw;
    logic [c_SW:0]    w_sh1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ISSUE;
            S_ISSUE: if (r_i == c_HALF_LAST) w_next = S_DRAIN;
            S_DRAIN: begin
                if (r_drain == '0) begin
                    w_next = (r_s == c_LAST_S) ? S_DONE : S_ISSUE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s     <= '0;
            r_i     <= '0;
            r_drain <= '0;
            r_mode  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_s    <= '0;
                        r_i    <= '0;
                    end
                end
                S_ISSUE: begin
                    if (r_i == c_HALF_LAST) begin
                        r_i     <= '0;
                        r_drain <= c_DRAIN_LOAD;
                    end else begin
                        r_i <= r_i + LOG_N'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_drain == '0) begin
                        if (r_s != c_LAST_S) r_s <= r_s + c_SW'(1);
                    end else begin
                        r_drain <= r_drain - c_DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // m = log2(butterfly span); group/position split i into index fields.
    always_comb begin
        w_m   = r_mode ? r_s : (c_LAST_S - r_s);
        w_sh1 = {1'b0, w_m} + (c_SW + 1)'(1);
        w_g   = r_i >> w_m;
        w_p   = r_i & ((LOG_N'(1) << w_m) - LOG_N'(1));
        w_a   = (w_g << w_sh1) | w_p;
        w_b   = w_a + (LOG_N'(1) << w_m);
        // 2^(LOG_N-m)-1 is simply an all-ones word shifted right by m.
        w_tw  = r_mode ? (({LOG_N{1'b1}} >> w_m) - w_g)
                       : ((LOG_N'(1) << r_s) + w_g);
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        rd_en     = (r_state == S_ISSUE);
        rd_addr_a = rd_en ? w_a  : '0;
        rd_addr_b = rd_en ? w_b  : '0;
        tw_idx    = rd_en ? w_tw : '0;
        bfu_mode  = r_mode;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PIPE_LAT; k++) r_dly[k] <= '0;
        end else begin
            r_dly[0] <= {rd_en, rd_addr_a, rd_addr_b};
            for (int k = 1; k < PIPE_LAT; k++) r_dly[k] <= r_dly[k-1];
        end
    end

    assign {wr_en, wr_addr_a, wr_addr_b} = r_dly[PIPE_LAT-1];

`ifdef NTT_SCHED_PERF_EN
    logic [31:0] r_cyc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_cyc <= '0;
        end else if (busy) begin
            r_cyc <= r_cyc + 32'd1;
        end
    end

    assign cyc_cnt = r_cyc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ntt_sched.sv
// ============================================================================
// Module  : tb_ntt_sched
// Purpose : Self-checking bench for ntt_sched (defaults and LOG_N=4/PIPE_LAT=3).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ntt_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start0, mode0, start1, mode1, sel;

    logic       d0_busy, d0_done, d0_rd_en, d0_bfu, d0_wr_en;
    logic [7:0] d0_ra, d0_rb, d0_tw, d0_wa, d0_wb;
    logic       d1_busy, d1_done, d1_rd_en, d1_bfu, d1_wr_en;
    logic [3:0] d1_ra, d1_rb, d1_tw, d1_wa, d1_wb;
`ifdef NTT_SCHED_PERF_EN
    logic [31:0] d0_cyc, d1_cyc;
`endif

    ntt_sched #(.LOG_N(8), .PIPE_LAT(9)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode0),
        .busy(d0_busy), .done(d0_done), .rd_en(d0_rd_en),
        .rd_addr_a(d0_ra), .rd_addr_b(d0_rb), .tw_idx(d0_tw),
        .bfu_mode(d0_bfu), .wr_en(d0_wr_en),
        .wr_addr_a(d0_wa), .wr_addr_b(d0_wb)
`ifdef NTT_SCHED_PERF_EN
        , .cyc_cnt(d0_cyc)
`endif
    );

    ntt_sched #(.LOG_N(4), .PIPE_LAT(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1),
        .busy(d1_busy), .done(d1_done), .rd_en(d1_rd_en),
        .rd_addr_a(d1_ra), .rd_addr_b(d1_rb), .tw_idx(d1_tw),
        .bfu_mode(d1_bfu), .wr_en(d1_wr_en),
        .wr_addr_a(d1_wa), .wr_addr_b(d1_wb)
`ifdef NTT_SCHED_PERF_EN
        , .cyc_cnt(d1_cyc)
`endif
    );

    logic       m_busy, m_done, m_rd_en, m_bfu, m_wr_en;
    logic [7:0] m_ra, m_rb, m_tw, m_wa, m_wb;
    always_comb begin
        m_busy  = sel ? d1_busy  : d0_busy;
        m_done  = sel ? d1_done  : d0_done;
        m_rd_en = sel ? d1_rd_en : d0_rd_en;
        m_bfu   = sel ? d1_bfu   : d0_bfu;
        m_wr_en = sel ? d1_wr_en : d0_wr_en;
        m_ra    = sel ? {4'b0, d1_ra} : d0_ra;
        m_rb    = sel ? {4'b0, d1_rb} : d0_rb;
        m_tw    = sel ? {4'b0, d1_tw} : d0_tw;
        m_wa    = sel ? {4'b0, d1_wa} : d0_wa;
        m_wb    = sel ? {4'b0, d1_wb} : d0_wb;
    end

    int gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    typedef struct packed { logic [7:0] a; logic [7:0] b; logic [7:0] tw; } rd_t;
    typedef struct packed { logic [7:0] a; logic [7:0] b; int k; } wr_t;
    typedef struct packed { logic rd; logic [7:0] a; logic [7:0] b; logic [7:0] tw; logic wr; logic dn; } tr_t;
    typedef struct { int md; int cyc; int rd; int a; int b; int tw; int wr; int dn; } vec_t;

    rd_t exp_q[$];
    wr_t wq[$];
    tr_t trace [2][1200];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference order of butterflies written as the textbook loop nest.
    task automatic build_model(input int logn, input bit md);
        int n;
        int k;
        rd_t e;
        n = 1 << logn;
        exp_q.delete();
        if (!md) begin
            k = 1;
            for (int len = n / 2; len >= 1; len = len / 2)
                for (int st = 0; st < n; st += 2 * len) begin
                    for (int j = 0; j < len; j++) begin
                        e.a = 8'(st + j); e.b = 8'(st + j + len); e.tw = 8'(k);
                        exp_q.push_back(e);
                    end
                    k++;
                end
        end else begin
            k = n - 1;
            for (int len = 1; len < n; len = len * 2)
                for (int st = 0; st < n; st += 2 * len) begin
                    for (int j = 0; j < len; j++) begin
                        e.a = 8'(st + j); e.b = 8'(st + j + len); e.tw = 8'(k);
                        exp_q.push_back(e);
                    end
                    k--;
                end
        end
    endtask

    task automatic all_zero(input string nm);
        chk(nm, {m_busy, m_done, m_rd_en, m_bfu, m_wr_en, m_ra, m_rb, m_tw, m_wa, m_wb}, 0);
    endtask

    // Called at a negedge; starts a run and follows it to done with the scoreboard.
    task automatic run(input bit s, input bit md, input bit hold, input int exp_w,
                       output int acc_g, output int done_g);
        int logn, plat, half, exp_done, nrd, nwr, w, done_k, hits;
        rd_t e;
        wr_t we;
        logn = s ? 4 : 8;
        plat = s ? 3 : 9;
        half = (1 << logn) / 2;
        exp_done = 1 + logn * (half + plat);
        nrd = 0; nwr = 0; done_k = 0; w = 0; done_g = 0;
        build_model(logn, md);
        wq.delete();
        sel = s;
        if (s) begin start1 = 1'b1; mode1 = md; end
        else   begin start0 = 1'b1; mode0 = md; end
        do begin
            @(posedge clk); #1; w++;
        end while (!m_busy && w < 5);
        acc_g = gcyc;
        chk("accept_edges", w, exp_w);
`ifdef NTT_SCHED_PERF_EN
        if (!s) chk("cyc_cnt_cleared", d0_cyc, 0);
`endif
        if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
        for (int k = 1; k <= exp_done + 20; k++) begin
            @(negedge clk);
            if (m_rd_en) begin
                nrd++;
                hits = 0;
                foreach (wq[j])
                    if (wq[j].a == m_ra || wq[j].b == m_ra || wq[j].a == m_rb || wq[j].b == m_rb) hits++;
                chk($sformatf("hazard_c%0d", k), hits, 0);
                if (exp_q.size() == 0) begin
                    chk($sformatf("extra_rd_c%0d", k), 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("rd_c%0d", k), {m_ra, m_rb, m_tw}, {e.a, e.b, e.tw});
                end
                we.a = m_ra; we.b = m_rb; we.k = k;
                wq.push_back(we);
            end else begin
                chk($sformatf("rd_idle_c%0d", k), {m_ra, m_rb, m_tw}, 0);
            end
            if (m_wr_en) begin
                nwr++;
                if (wq.size() == 0) begin
                    chk($sformatf("extra_wr_c%0d", k), 1, 0);
                end else begin
                    we = wq.pop_front();
                    chk($sformatf("wr_c%0d", k), {m_wa, m_wb}, {we.a, we.b});
                    chk($sformatf("wr_lat_c%0d", k), k - we.k, plat);
                end
            end
            if (!s && k < 1200)
                trace[md][k] = {m_rd_en, m_ra, m_rb, m_tw, m_wr_en, m_done};
            if (m_done) begin
                done_k = k;
                done_g = gcyc;
                break;
            end
        end
        chk("done_cycle", done_k, exp_done);
        chk("rd_count", nrd, logn * half);
        chk("wr_count", nwr, logn * half);
        chk("rd_left", exp_q.size(), 0);
        chk("wr_left", wq.size(), 0);
        chk("bfu_mode", m_bfu, md);
    endtask

    vec_t tbl[15];
    int acc_a, done_a, acc_b, done_b;

    initial begin
        tbl[0]  = '{0, 1,    1, 0,   128, 1,   0, 0};
        tbl[1]  = '{0, 2,    1, 1,   129, 1,   0, 0};
        tbl[2]  = '{0, 10,   1, 9,   137, 1,   1, 0};
        tbl[3]  = '{0, 128,  1, 127, 255, 1,   1, 0};
        tbl[4]  = '{0, 129,  0, 0,   0,   0,   1, 0};
        tbl[5]  = '{0, 137,  0, 0,   0,   0,   1, 0};
        tbl[6]  = '{0, 138,  1, 0,   64,  2,   0, 0};
        tbl[7]  = '{0, 1087, 1, 254, 255, 255, 1, 0};
        tbl[8]  = '{0, 1096, 0, 0,   0,   0,   1, 0};
        tbl[9]  = '{0, 1097, 0, 0,   0,   0,   0, 1};
        tbl[10] = '{1, 1,    1, 0,   1,   255, 0, 0};
        tbl[11] = '{1, 2,    1, 2,   3,   254, 0, 0};
        tbl[12] = '{1, 128,  1, 254, 255, 128, 1, 0};
        tbl[13] = '{1, 960,  1, 0,   128, 1,   0, 0};
        tbl[14] = '{1, 961,  1, 1,   129, 1,   0, 0};

        rst = 1'b1; start0 = 1'b0; mode0 = 1'b0; start1 = 1'b0; mode1 = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        all_zero("reset_dut0");
        sel = 1'b1; #1;
        all_zero("reset_dut1");
        sel = 1'b0;

        // Release reset and start on the same cycle.
        rst = 1'b0;
        run(0, 0, 0, 1, acc_a, done_a);
`ifdef NTT_SCHED_PERF_EN
        @(negedge clk);
        chk("cyc_cnt_final", d0_cyc, 1097);
`endif
        @(negedge clk);
        run(0, 1, 0, 1, acc_a, done_a);

        for (int v = 0; v < 15; v++) begin
            tr_t t;
            t = trace[tbl[v].md][tbl[v].cyc];
            chk($sformatf("tbl%0d", v),
                {t.rd, t.a, t.b, t.tw, t.wr, t.dn},
                {1'(tbl[v].rd), 8'(tbl[v].a), 8'(tbl[v].b), 8'(tbl[v].tw), 1'(tbl[v].wr), 1'(tbl[v].dn)});
        end

        @(negedge clk);
        run(1, 0, 0, 1, acc_a, done_a);
        @(negedge clk);
        run(1, 1, 0, 1, acc_a, done_a);

        // start held high through a whole run and on into the next.
        @(negedge clk);
        run(0, 0, 1, 1, acc_a, done_a);
        run(0, 0, 1, 2, acc_b, done_b);
        start0 = 1'b0;
        chk("restart_gap", acc_b - done_a, 2);
        chk("two_dones", (done_b > done_a) ? 1 : 0, 1);

        // Abort a forward run with reset in cycle 300.
        @(negedge clk);
        @(negedge clk);
        sel = 1'b0; mode0 = 1'b0; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int k = 1; k < 300; k++) @(negedge clk);
        chk("pre_abort_busy", m_busy, 1);
        rst = 1'b1; #1;
        all_zero("abort_now");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            all_zero($sformatf("abort_hold%0d", k));
        end
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk($sformatf("post_abort%0d", k), {m_busy, m_wr_en, m_rd_en}, 0);
        end
        run(0, 0, 0, 1, acc_a, done_a);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
